// File: rtl/fpu_share_arb.sv
// rtl/fpu_share_arb.sv - round-robin arbiter/issue sequencer sharing one AXIS FPU
//
// Grants one of N_REQ requesters at a time, drives the FPU operand channels A/B,
// and records the winner in an in-order tag FIFO so each returned result can be
// steered back to its issuer. Up to DEPTH operations may be outstanding.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid[N_REQ]           per-requester operation request
//   req_adata/req_bdata        packed 32-bit operands, requester i at [32i+31:32i]
//   req_ready[N_REQ]           one-hot accept pulse
//   resp_data, resp_valid      returned result and one-hot owner pulse
//   busy                       issuing or operations outstanding
//   fpu_a_*, fpu_b_*           operand AXIS masters
//   fpu_r_*                    result AXIS slave
module fpu_share_arb #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_adata,
  input  logic [32*N_REQ-1:0]  req_bdata,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          resp_data,
  output logic [N_REQ-1:0]     resp_valid,
  output logic                 busy,
  output logic [31:0]          fpu_a_tdata,
  output logic                 fpu_a_tvalid,
  input  logic                 fpu_a_tready,
  output logic [31:0]          fpu_b_tdata,
  output logic                 fpu_b_tvalid,
  input  logic                 fpu_b_tready,
  input  logic [31:0]          fpu_r_tdata,
  input  logic                 fpu_r_tvalid,
  output logic                 fpu_r_tready
);

  localparam int TW = $clog2(N_REQ);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] last_grant;
  logic [TW-1:0] grant_idx;
  logic [TW-1:0] cand;
  logic          grant_found;
  logic          grant;
  logic          pop;
  logic [31:0]   a_arr [N_REQ];
  logic [31:0]   b_arr [N_REQ];
  logic [TW-1:0] tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_adata[32*i +: 32];
    assign b_arr[i] = req_bdata[32*i +: 32];
  end

  // Scan from lowest to highest priority so the highest-priority valid
  // candidate (last_grant+1) is the last one written and therefore wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = TW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A grant needs a free tag; a pop on the same edge only frees it for the next edge.
  assign grant        = (state == IDLE) && grant_found && (count < (PW+1)'(DEPTH));
  assign fpu_r_tready = (count != '0);
  assign pop          = fpu_r_tvalid && fpu_r_tready;
  assign busy         = (state == ISSUE) || (count != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if ((!fpu_a_tvalid || fpu_a_tready) && (!fpu_b_tvalid || fpu_b_tready))
                 state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= TW'(N_REQ - 1);
      fpu_a_tdata  <= '0;
      fpu_b_tdata  <= '0;
      fpu_a_tvalid <= 1'b0;
      fpu_b_tvalid <= 1'b0;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state      <= state_nxt;
      req_ready  <= '0;
      resp_valid <= '0;

      if (grant) begin
        fpu_a_tdata  <= a_arr[grant_idx];
        fpu_b_tdata  <= b_arr[grant_idx];
        fpu_a_tvalid <= 1'b1;
        fpu_b_tvalid <= 1'b1;
        req_ready    <= N_REQ'(1) << grant_idx;
        last_grant   <= grant_idx;
        wr_ptr       <= wr_ptr + 1'b1;
      end else begin
        if (fpu_a_tready) fpu_a_tvalid <= 1'b0;
        if (fpu_b_tready) fpu_b_tvalid <= 1'b0;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        resp_data  <= fpu_r_tdata;
        resp_valid <= N_REQ'(1) << tag_mem[rd_ptr];
      end

      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: doc/fpu_share_arb.md
# fpu_share_arb

Round-robin arbiter and issue sequencer that shares one AXI4-Stream floating-point unit (fadd/fsub/fmul-style: operand channels A and B, one result channel) between N_REQ requesters in the core. Each requester presents a 32-bit operand pair. The block grants one requester at a time, drives both operand channels, and records the requester ID in an in-order tag FIFO. Each returned result is steered back to the requester that issued it. Up to DEPTH operations may be in flight, so the unit's pipeline stays full instead of being used one op at a time.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- DEPTH, 4: maximum outstanding operations (tag FIFO entries), power of two, 2..16.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_adata  in  32*N_REQ  operand A; requester i uses bits [32i+31:32i].
- req_bdata  in  32*N_REQ  operand B; same packing as req_adata.
- req_ready  out  N_REQ  one-hot, one-cycle pulse; the request has been accepted.
- resp_data  out  32  result of the most recently completed operation.
- resp_valid  out  N_REQ  one-hot, one-cycle pulse; resp_data belongs to this requester.
- busy  out  1  high if state is ISSUE or any operation is outstanding.
- fpu_a_tdata/tvalid  out  32/1, fpu_a_tready  in  1: operand A AXIS master.
- fpu_b_tdata/tvalid  out  32/1, fpu_b_tready  in  1: operand B AXIS master.
- fpu_r_tdata  in  32, fpu_r_tvalid  in  1, fpu_r_tready  out  1: result AXIS slave.

## Operation
- State machine with two states:
  - IDLE: on each edge, if |req_valid and count < DEPTH, grant one requester (winner g). The same edge latches g's operands into fpu_a_tdata/fpu_b_tdata registers, sets both tvalids, pushes g into the tag FIFO, sets req_ready[g] for exactly one cycle, updates last_grant <= g, and moves to ISSUE. Otherwise remain in IDLE.
  - ISSUE: each tvalid clears independently on the edge at which its tready is sampled high. On the edge where the last remaining tvalid clears (both may clear on the same edge), move to IDLE. tdata is held stable while the matching tvalid is high.
- Arbitration is round-robin. Priority starts at (last_grant+1) mod N_REQ and increases with index, wrapping. Reset sets last_grant = N_REQ-1, so requester 0 has first priority.
- Requester contract: hold req_valid and data stable until req_ready is seen. On the edge where req_ready is high, drop req_valid or present the next operation. Because the earliest possible next grant is 2 edges after a grant, the same request is never granted twice.
- Tag FIFO: DEPTH entries of clog2(N_REQ) bits, with wrapping read/write pointers and a count of 0..DEPTH.
  - fpu_r_tready = (count != 0), combinational.
  - On a result handshake: pop tag t, resp_data <= fpu_r_tdata, resp_valid <= one-hot(t) for one cycle.
- If a grant push and a result pop occur on the same edge, count is unchanged and both pointers advance.
- Full: when count == DEPTH, no grant occurs and requests wait. A pop in the same cycle does not enable a grant until the next edge.
- Empty: fpu_r_tready is low. A result arriving with fpu_r_tvalid high is ignored until a tag exists. This is a unit protocol violation and is flagged by a bench assertion.
- Results return in issue order. The unit is in-order by contract.

## Timing
- Reset values: fpu_a_tvalid = 0, fpu_b_tvalid = 0, fpu_a_tdata = 0, fpu_b_tdata = 0, req_ready = 0, resp_valid = 0, resp_data = 0, state = IDLE, count = 0, both FIFO pointers = 0, last_grant = N_REQ-1. This gives fpu_r_tready = 0 and busy = 0.
- Grant latency: req_valid high before edge E0 gives req_ready and both tvalids high in the cycle after E0.
- Issue rate: with both treadys held high, one grant every 2 cycles.
- Result to response: fpu_r_tvalid & fpu_r_tready at edge E gives resp_valid/resp_data visible in the cycle after E.
- rst asserted mid-operation: all state clears on that edge. In-flight results are lost. The bench must also reset the FPU unit.
- busy = (state == ISSUE) | (count != 0), combinational.

## Test plan
- Single op, req 2: A=0x3F800000, B=0x3F000000, unit model with fixed 3-cycle latency returns 0x3F000000. Expect req_ready = 0100 one cycle after request, then resp_valid = 0100 with resp_data = 0x3F000000, and busy low afterwards.
- All 4 requesting continuously, treadys high, results returned as A XOR B. Expect grant order 0,1,2,3,0,… with one grant every 2 cycles. Each resp_valid bit must match the requester's operands.
- fpu_a_tready held low 5 cycles and fpu_b_tready high. Expect fpu_b_tvalid to drop after 1 cycle, fpu_a_tdata stable, ISSUE exited only after A handshakes, and no new grant meanwhile.
- Unit stalls results (fpu_r_tvalid = 0) with DEPTH = 4. Expect exactly 4 grants, then count = 4 and all req_ready low. Releasing one result must permit exactly one further grant, with no overflow.
- Same-edge grant and result pop at count = 2. Expect count to stay 2 and tags to return in issue order.
- rst pulsed while count = 3 and in ISSUE. Expect every output at its reset value the next cycle, and requester 0 winning the first grant after reset.
